pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5: number of pipeline stages, legal range 3..8; the stage 0..STAGES-2 boundaries are the inter-stage registers.
REQ-002 Parameter COMMIT, default 3: the first stage that is not squashed by a flush; legal range 1..STAGES-1.
REQ-003 Parameter OUTSTANDING, default 2: maximum number of in-flight data requests and instruction requests, each tracked separately; legal range 1..7.
REQ-004 clk  in  1  clock; one clock domain only.
REQ-005 resetn  in  1  reset, synchronous and active-low.
REQ-006 stage_busy  in  STAGES  per-stage local stall request (cache miss, div/mul busy).
REQ-007 hz_stall  in  STAGES  per-stage hazard stall request (load-use, branch operand not ready).
REQ-008 fetch_valid  in  1  stage 0 holds a real instruction.
REQ-009 flush_req  in  1  exception or eret, resolved at stage COMMIT.
REQ-010 i_req, i_addr_ok, i_data_ok  in  1 each  instruction-port handshake.
REQ-011 d_req, d_addr_ok, d_data_ok  in  1 each  data-port handshake.
REQ-012 stall  out  STAGES  per-stage hold.
REQ-013 refresh  out  STAGES-1  clear the register between stage i and stage i+1.
REQ-014 valid  out  STAGES  per-stage occupancy.
REQ-015 i_discard  out  1  the current i_data_ok response is stale and must be dropped.
REQ-016 d_block, i_block  out  1 each  the outstanding limit has been reached; no new request may be issued.
REQ-017 d_cnt, i_cnt  out  3 each  current outstanding counts.
REQ-018 cnt_err  out  1  sticky flag: a data_ok arrived while the matching count was 0.

Function
REQ-019 stall[STAGES-1] = stage_busy[STAGES-1] | hz_stall[STAGES-1].
REQ-020 For i < STAGES-1, stall[i] = stage_busy[i] | hz_stall[i] | stall[i+1]. This is combinational backward propagation.
REQ-021 stall[0] is additionally forced to 1 while the FSM is in DRAIN.
REQ-022 refresh[i] = (stall[i] & !stall[i+1]) | squash[i], where squash[i] = FSM in FLUSH and i < COMMIT. When stage i stalls but stage i+1 does not, a bubble is inserted into stage i+1.
REQ-023 valid[i+1] update each clock: clear to 0 if refresh[i]; else load valid[i] if !stall[i]; else hold.
REQ-024 valid[0] update each clock: load fetch_valid if !stall[0]; clear to 0 if in FLUSH.
REQ-025 d_cnt update: +1 on d_req&d_addr_ok, -1 on d_data_ok; both in the same cycle leave it unchanged.
REQ-026 i_cnt follows the same rules using the i_* signals.
REQ-027 d_block = (d_cnt == OUTSTANDING); i_block likewise with i_cnt. An accept while at the limit does not increment; the count saturates.
REQ-028 A data_ok arriving while the matching count is 0 leaves that count at 0 and sets cnt_err, which holds until reset.
REQ-029 FSM states are IDLE, FLUSH and DRAIN.
REQ-030 IDLE -> FLUSH on flush_req.
REQ-031 FLUSH lasts exactly 1 cycle; it goes to DRAIN if i_cnt, after that cycle's update, is non-zero, otherwise to IDLE. On entry to FLUSH, discard_cnt loads i_cnt.
REQ-032 DRAIN: i_discard = i_data_ok & (discard_cnt != 0); each discarded response decrements discard_cnt; the FSM goes to IDLE when discard_cnt reaches 0.
REQ-033 flush_req while in FLUSH or DRAIN re-enters FLUSH and reloads discard_cnt from the live i_cnt.
REQ-034 flush_req has priority over stall: squashed registers refresh even when stalled. Stages >= COMMIT still obey stall.

Reset
REQ-035 While resetn = 0 at a clk edge: valid = 0, d_cnt = i_cnt = 0, discard_cnt = 0, cnt_err = 0, FSM = IDLE.
REQ-036 A reset in the middle of FLUSH or DRAIN abandons the drain. No i_discard is asserted after reset is released.
REQ-037 The combinational outputs (stall, refresh, blocks) follow their inputs during reset.

Configuration
REQ-038 With PIPE_CTRL_PERF_EN defined, add the outputs perf_stall_cyc (32 bits, counts cycles with stall[0]=1), perf_flush_cnt (32 bits, counts FLUSH entries) and perf_bubble_cnt (32 bits, counts cycles with any refresh bit = 1 outside FLUSH). All three wrap at 2^32 and reset to 0.
REQ-039 Without PIPE_CTRL_PERF_EN, these ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-040 STAGES=5, hz_stall[1]=1 for 1 cycle with no other stall -> stall=5'b00011, refresh[1]=1; next cycle valid[2]=0 and stages 0-1 hold.
REQ-041 stage_busy[4]=1 for 3 cycles -> stall=5'b11111 for those 3 cycles, refresh=0, and all valid bits hold.
REQ-042 OUTSTANDING=2: two d_req&d_addr_ok accepts -> d_cnt=2 and d_block=1; a simultaneous accept and d_data_ok -> d_cnt stays 2; a lone d_data_ok -> d_cnt=1 and d_block=0.
REQ-043 i_cnt=2, then flush_req -> 1 cycle of FLUSH with refresh[0..2]=1, then DRAIN; the next two i_data_ok responses each raise i_discard=1, the FSM returns to IDLE, and stall[0] is released.
REQ-044 A second flush_req arrives during DRAIN with discard_cnt=1 and i_cnt=2 -> FLUSH again and discard_cnt reloads to 2.
REQ-045 resetn=0 during DRAIN -> the next cycle is IDLE with i_discard=0, all counts 0 and valid=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/occupancy controller with outstanding instruction/data request tracking.
// Defining PIPE_CTRL_PERF_EN adds the perf_stall_cyc, perf_flush_cnt and perf_bubble_cnt counters.
module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int COMMIT      = 3,
  parameter int OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [STAGES-1:0] stage_busy,
  input  logic [STAGES-1:0] hz_stall,
  input  logic              fetch_valid,
  input  logic              flush_req,
  input  logic              i_req,
  input  logic              i_addr_ok,
  input  logic              i_data_ok,
  input  logic              d_req,
  input  logic              d_addr_ok,
  input  logic              d_data_ok,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-2:0] refresh,
  output logic [STAGES-1:0] valid,
  output logic              i_discard,
  output logic              d_block,
  output logic              i_block,
  output logic [2:0]        d_cnt,
  output logic [2:0]        i_cnt,
  output logic              cnt_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [2:0] OUT_LIMIT = 3'(OUTSTANDING);

  logic [1:0]        state_q, state_d;
  logic [2:0]        discardCnt_q, discardCnt_d;
  logic [2:0]        dCnt_q, dCnt_d;
  logic [2:0]        iCnt_q, iCnt_d;
  logic              cntErr_q, cntErr_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              stallChain;

  // Saturating counter step; a simultaneous accept and response cancel out.
  function automatic logic [2:0] nextCnt(input logic [2:0] cnt, input logic acc, input logic ok);
    logic [2:0] res;
    res = cnt;
    if (acc && !ok && cnt != OUT_LIMIT) res = cnt + 3'd1;
    else if (ok && !acc && cnt != 3'd0) res = cnt - 3'd1;
    return res;
  endfunction

  always_comb begin
    stall      = '0;
    stallChain = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stallChain = stallChain | stage_busy[i] | hz_stall[i];
      stall[i]   = stallChain;
    end
    if (state_q == DRAIN) stall[0] = 1'b1;
  end

  always_comb begin
    refresh = '0;
    for (int i = 0; i < STAGES - 1; i++) begin
      refresh[i] = (stall[i] & ~stall[i+1]) | ((state_q == FLUSH) && (i < COMMIT));
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (state_q == FLUSH) valid_d[0] = 1'b0;
    else if (!stall[0]) valid_d[0] = fetch_valid;
    for (int i = 0; i < STAGES - 1; i++) begin
      if (refresh[i]) valid_d[i+1] = 1'b0;
      else if (!stall[i]) valid_d[i+1] = valid_q[i];
    end
  end

  always_comb begin
    dCnt_d   = nextCnt(dCnt_q, d_req & d_addr_ok, d_data_ok);
    iCnt_d   = nextCnt(iCnt_q, i_req & i_addr_ok, i_data_ok);
    cntErr_d = cntErr_q | (d_data_ok & (dCnt_q == 3'd0)) | (i_data_ok & (iCnt_q == 3'd0));
  end

  // A new flush always wins and re-arms the discard count from the live in-flight count.
  always_comb begin
    state_d      = state_q;
    discardCnt_d = discardCnt_q;
    i_discard    = 1'b0;
    case (state_q)
      IDLE:  state_d = IDLE;
      FLUSH: state_d = (iCnt_d != 3'd0) ? DRAIN : IDLE;
      DRAIN: begin
        i_discard    = i_data_ok & (discardCnt_q != 3'd0);
        discardCnt_d = discardCnt_q - {2'b00, i_discard};
        if (discardCnt_d == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_req) begin
      state_d      = FLUSH;
      discardCnt_d = iCnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      discardCnt_q <= 3'd0;
      dCnt_q       <= 3'd0;
      iCnt_q       <= 3'd0;
      cntErr_q     <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      discardCnt_q <= discardCnt_d;
      dCnt_q       <= dCnt_d;
      iCnt_q       <= iCnt_d;
      cntErr_q     <= cntErr_d;
      valid_q      <= valid_d;
    end
  end

  assign valid   = valid_q;
  assign d_cnt   = dCnt_q;
  assign i_cnt   = iCnt_q;
  assign cnt_err = cntErr_q;
  assign d_block = (dCnt_q == OUT_LIMIT);
  assign i_block = (iCnt_q == OUT_LIMIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perfStall_q, perfFlush_q, perfBubble_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perfStall_q  <= 32'd0;
      perfFlush_q  <= 32'd0;
      perfBubble_q <= 32'd0;
    end else begin
      perfStall_q  <= perfStall_q + 32'(stall[0]);
      perfFlush_q  <= perfFlush_q + 32'(flush_req);
      perfBubble_q <= perfBubble_q + 32'((|refresh) && (state_q != FLUSH));
    end
  end

  assign perf_stall_cyc  = perfStall_q;
  assign perf_flush_cnt  = perfFlush_q;
  assign perf_bubble_cnt = perfBubble_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (STAGES=5, COMMIT=3, OUTSTANDING=2): a queue-fed monitor
// compares every cycle against a reference model, plus directed boundary scenarios.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] stage_busy, hz_stall;
  logic       fetch_valid, flush_req;
  logic       i_req, i_addr_ok, i_data_ok, d_req, d_addr_ok, d_data_ok;
  logic [4:0] stall, valid;
  logic [3:0] refresh;
  logic       i_discard, d_block, i_block, cnt_err;
  logic [2:0] d_cnt, i_cnt;

  pipe_ctrl #(.STAGES(5), .COMMIT(3), .OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn), .stage_busy(stage_busy), .hz_stall(hz_stall),
    .fetch_valid(fetch_valid), .flush_req(flush_req),
    .i_req(i_req), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .stall(stall), .refresh(refresh), .valid(valid), .i_discard(i_discard),
    .d_block(d_block), .i_block(i_block), .d_cnt(d_cnt), .i_cnt(i_cnt), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] stall;
    logic [3:0] refresh;
    logic [4:0] valid;
    logic       idisc, dblk, iblk, err;
    logic [2:0] dcnt, icnt;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: pipeline occupancy, request counts, and flush/drain progress.
  logic [4:0] mValid;
  int         mD, mI, mDisc;
  bit         mErr, mFlush, mDrain;
  bit         mKnown = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cntStep(input int c, input bit acc, input bit ok);
    if (acc && ok) return c;
    if (acc) return (c < 2) ? c + 1 : c;
    if (ok) return (c > 0) ? c - 1 : c;
    return c;
  endfunction

  task automatic applyStimulus(input logic [4:0] busy, input logic [4:0] hz, input bit fv,
                               input bit fl, input bit ir, input bit iaok, input bit idok,
                               input bit dr, input bit daok, input bit ddok, input bit rstn);
    exp_t       e;
    logic [4:0] nv;
    logic [4:0] anyStall;
    int         oldI;
    @(negedge clk);
    stage_busy = busy; hz_stall = hz; fetch_valid = fv; flush_req = fl;
    i_req = ir; i_addr_ok = iaok; i_data_ok = idok;
    d_req = dr; d_addr_ok = daok; d_data_ok = ddok; resetn = rstn;

    anyStall = busy | hz;
    for (int i = 0; i < 5; i++) e.stall[i] = ((anyStall >> i) != 5'd0);
    if (mDrain) e.stall[0] = 1'b1;
    for (int i = 0; i < 4; i++) e.refresh[i] = (e.stall[i] && !e.stall[i+1]) || (mFlush && i < 3);
    e.valid = mValid;
    e.idisc = mDrain && idok && (mDisc > 0);
    e.dblk  = (mD == 2);
    e.iblk  = (mI == 2);
    e.dcnt  = 3'(mD);
    e.icnt  = 3'(mI);
    e.err   = mErr;
    if (mKnown) expQ.push_back(e);

    if (!rstn) begin
      mValid = '0; mD = 0; mI = 0; mDisc = 0; mErr = 0; mFlush = 0; mDrain = 0; mKnown = 1;
    end else begin
      nv = mValid;
      if (mFlush) nv[0] = 1'b0;
      else if (!e.stall[0]) nv[0] = fv;
      for (int i = 0; i < 4; i++) begin
        if (e.refresh[i]) nv[i+1] = 1'b0;
        else if (!e.stall[i]) nv[i+1] = mValid[i];
      end
      mValid = nv;
      mErr = mErr || (ddok && mD == 0) || (idok && mI == 0);
      oldI = mI;
      mD = cntStep(mD, dr && daok, ddok);
      mI = cntStep(mI, ir && iaok, idok);
      if (mFlush) begin
        mFlush = 0;
        mDrain = (mI != 0);
      end else if (mDrain) begin
        if (e.idisc) mDisc--;
        if (mDisc == 0) mDrain = 0;
      end
      if (fl) begin
        mFlush = 1; mDrain = 0; mDisc = oldI;
      end
    end
  endtask

  task automatic idle(input bit fv);
    applyStimulus(5'd0, 5'd0, fv, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic iOnly(input bit ir, input bit idok, input bit fl);
    applyStimulus(5'd0, 5'd0, 1, fl, ir, ir, idok, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("stall", 32'(stall), 32'(e.stall));
        checkOutput("refresh", 32'(refresh), 32'(e.refresh));
        checkOutput("valid", 32'(valid), 32'(e.valid));
        checkOutput("i_discard", 32'(i_discard), 32'(e.idisc));
        checkOutput("d_block", 32'(d_block), 32'(e.dblk));
        checkOutput("i_block", 32'(i_block), 32'(e.iblk));
        checkOutput("d_cnt", 32'(d_cnt), 32'(e.dcnt));
        checkOutput("i_cnt", 32'(i_cnt), 32'(e.icnt));
        checkOutput("cnt_err", 32'(cnt_err), 32'(e.err));
      end
    end
  end

  initial begin : driver
    int waitCycles;
    stage_busy = '0; hz_stall = '0; fetch_valid = 0; flush_req = 0;
    i_req = 0; i_addr_ok = 0; i_data_ok = 0; d_req = 0; d_addr_ok = 0; d_data_ok = 0;
    resetn = 0;
    repeat (2) applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0); #2;
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_cnts", {26'd0, d_cnt, i_cnt}, 32'd0);

    // Hazard bubble at stage 1
    repeat (6) idle(1);
    applyStimulus(5'd0, 5'b00010, 1, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    checkOutput("hz_stall_vec", 32'(stall), 32'b00011);
    checkOutput("hz_refresh1", 32'(refresh[1]), 32'd1);
    idle(1); #2;
    checkOutput("hz_bubble_v2", 32'(valid[2]), 32'd0);
    checkOutput("hz_hold_v01", 32'(valid[1:0]), 32'b11);

    // Tail stage busy stalls everything
    repeat (3) begin
      applyStimulus(5'b10000, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
      checkOutput("busy4_stall", 32'(stall), 32'b11111);
      checkOutput("busy4_refresh", 32'(refresh), 32'd0);
    end

    // Data outstanding limit
    repeat (2) applyStimulus(5'd0, 5'd0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    applyStimulus(5'd0, 5'd0, 1, 0, 0, 0, 0, 1, 1, 1, 1); #2;
    checkOutput("d_cnt_two", 32'(d_cnt), 32'd2);
    checkOutput("d_block_set", 32'(d_block), 32'd1);
    applyStimulus(5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 0, 1, 1); #2;
    checkOutput("d_cnt_same", 32'(d_cnt), 32'd2);
    idle(1); #2;
    checkOutput("d_cnt_one", 32'(d_cnt), 32'd1);
    checkOutput("d_block_clr", 32'(d_block), 32'd0);

    // Flush with two in-flight fetches
    iOnly(1, 0, 0); iOnly(1, 0, 0);
    iOnly(0, 0, 1); #2;
    checkOutput("flush_icnt", 32'(i_cnt), 32'd2);
    iOnly(0, 0, 0); #2;
    checkOutput("flush_refresh", 32'(refresh[2:0]), 32'b111);
    repeat (2) begin
      iOnly(0, 1, 0); #2;
      checkOutput("drain_discard", 32'(i_discard), 32'd1);
      checkOutput("drain_stall0", 32'(stall[0]), 32'd1);
    end
    iOnly(0, 0, 0); #2;
    checkOutput("drain_release", 32'(stall[0]), 32'd0);

    // Re-flush during drain reloads the discard count
    iOnly(1, 0, 0); iOnly(1, 0, 0);
    iOnly(0, 0, 1); iOnly(0, 0, 0);
    iOnly(0, 1, 0); iOnly(1, 0, 0);
    iOnly(0, 0, 1); iOnly(0, 0, 0); #2;
    checkOutput("reflush_refresh0", 32'(refresh[0]), 32'd1);
    repeat (2) begin
      iOnly(0, 1, 0); #2;
      checkOutput("reflush_discard", 32'(i_discard), 32'd1);
    end
    iOnly(0, 0, 0); #2;
    checkOutput("reflush_release", 32'(stall[0]), 32'd0);

    // Reset in the middle of a drain
    iOnly(1, 0, 0); iOnly(1, 0, 0);
    iOnly(0, 0, 1); iOnly(0, 0, 0);
    applyStimulus(5'd0, 5'd0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    iOnly(0, 1, 0); #2;
    checkOutput("rst_drain_disc", 32'(i_discard), 32'd0);
    checkOutput("rst_drain_cnt", 32'(i_cnt), 32'd0);
    checkOutput("rst_drain_valid", 32'(valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(
        5'(($urandom_range(0, 7) == 0) ? (1 << $urandom_range(0, 4)) : 0),
        5'(($urandom_range(0, 7) == 0) ? (1 << $urandom_range(0, 4)) : 0),
        1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
        1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
        1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
        1'($urandom_range(0, 59) != 0));
    end
    idle(0);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    #3;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
